// File: rtl/quad_gate_tester_if.sv
// quad_gate_tester_if
// Bundles the signals between the sweep sequencer and the rest of the system:
// the gate-under-test bus (a, b driven out, y returned) plus the control and
// result signals (start in; busy, done, pass, err_count, fail_valid and the
// captured first-fail vector out).
//   master : the sequencer side (drives a/b and the results, receives start/y)
//   slave  : the environment side (drives start/y, receives everything else)
interface quad_gate_tester_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] err_count;
    logic       fail_valid;
    logic [3:0] first_fail_a;
    logic [3:0] first_fail_b;
    logic [3:0] first_fail_y;

    modport master (
        input  start, y,
        output a, b, busy, done, pass, err_count,
               fail_valid, first_fail_a, first_fail_b, first_fail_y
    );

    modport slave (
        output start, y,
        input  a, b, busy, done, pass, err_count,
               fail_valid, first_fail_a, first_fail_b, first_fail_y
    );
endinterface

// File: rtl/quad_gate_tester.sv
// quad_gate_tester
// Self-test sequencer for a 74-series quad 2-input gate model. On start it
// sweeps all 256 (a,b) combinations, holds each for SETTLE_CYCLES clocks,
// compares y against the expected function on the last clock of the hold,
// and records the mismatch count and the first failing vector.
// Parameters:
//   OP            : 0=OR, 1=AND, 2=XOR, 3=NAND (expected function per bit)
//   SETTLE_CYCLES : clocks each vector is held before y is compared (>=1)
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : quad_gate_tester_if.master (start, a, b, y, busy, done, pass,
//          err_count, fail_valid, first_fail_a/b/y)
module quad_gate_tester #(
    parameter int OP            = 0,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    quad_gate_tester_if.master    bus
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [7:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [8:0]       r_err_count;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_fail_valid;
    logic [3:0]       r_ff_a;
    logic [3:0]       r_ff_b;
    logic [3:0]       r_ff_y;

    logic [3:0]       w_a;
    logic [3:0]       w_b;
    logic [3:0]       w_exp;
    logic             w_mismatch;
    logic [8:0]       w_err_next;
    logic             w_start_acc;
    logic             w_compare;
    logic             w_last;

    // The vector index is the gate input: a is the high nibble, b the low.
    assign w_a = r_idx[7:4];
    assign w_b = r_idx[3:0];

    // Expected gate output, one bit slice per gate of the quad package.
    for (genvar gi = 0; gi < 4; gi++) begin : g_exp
        if (OP == 0) begin : g_or
            assign w_exp[gi] = w_a[gi] | w_b[gi];
        end else if (OP == 1) begin : g_and
            assign w_exp[gi] = w_a[gi] & w_b[gi];
        end else if (OP == 2) begin : g_xor
            assign w_exp[gi] = w_a[gi] ^ w_b[gi];
        end else begin : g_nand
            assign w_exp[gi] = ~(w_a[gi] & w_b[gi]);
        end
    end

    assign w_mismatch = |(bus.y ^ w_exp);
    // Count including the current compare; needed for the final pass flag.
    assign w_err_next = r_err_count + {8'd0, w_mismatch};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_compare    = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_RUN;
                    w_start_acc  = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_compare = 1'b1;
                    if (r_idx == 8'hFF) begin
                        w_last       = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: vector index, settle counter, result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= 8'd0;
            r_cnt        <= '0;
            r_err_count  <= 9'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_ff_a       <= 4'd0;
            r_ff_b       <= 4'd0;
            r_ff_y       <= 4'd0;
        end else begin
            r_done <= 1'b0;
            if (w_start_acc) begin
                // pass is deliberately left alone: it reports the last
                // completed sweep until this one finishes.
                r_busy       <= 1'b1;
                r_idx        <= 8'd0;
                r_cnt        <= '0;
                r_err_count  <= 9'd0;
                r_fail_valid <= 1'b0;
                r_ff_a       <= 4'd0;
                r_ff_b       <= 4'd0;
                r_ff_y       <= 4'd0;
            end else if (r_state == ST_RUN) begin
                if (w_compare) begin
                    r_err_count <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_ff_a       <= w_a;
                        r_ff_b       <= w_b;
                        r_ff_y       <= bus.y;
                    end
                    if (w_last) begin
                        // idx stays at 8'hFF so a and b hold 4'hF afterwards.
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_err_next == 9'd0);
                    end else begin
                        r_idx <= r_idx + 8'd1;
                        r_cnt <= '0;
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.a            = w_a;
    assign bus.b            = w_b;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.pass         = r_pass;
    assign bus.err_count    = r_err_count;
    assign bus.fail_valid   = r_fail_valid;
    assign bus.first_fail_a = r_ff_a;
    assign bus.first_fail_b = r_ff_b;
    assign bus.first_fail_y = r_ff_y;

endmodule

// File: tb/tb_quad_gate_tester.sv
// tb_quad_gate_tester
// Runs five sequencer instances (different OP / SETTLE_CYCLES) side by side,
// each attached to its own copy of a configurable gate model (selectable
// function, optional one-register delay, stuck-at bits and a per-vector
// corruption table). Expected results come from a loop over all 256 vectors.
module tb_quad_gate_tester;

    localparam int NI     = 5;
    localparam int WINDOW = 775;

    function automatic int op_of(input int i);
        case (i)
            0:       return 0;
            1:       return 0;
            2:       return 3;
            3:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int s_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 1;
            3:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [3:0] gate_fn(input logic [1:0] op, input logic [3:0] x,
                                           input logic [3:0] z);
        case (op)
            2'd0:    return x | z;
            2'd1:    return x & z;
            2'd2:    return x ^ z;
            default: return ~(x & z);
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_drv = 1'b0;

    always #5 clk = ~clk;

    // Gate model configuration shared by all instances
    logic [1:0] model_op = 2'd0;
    logic       model_delay = 1'b0;
    logic [3:0] stuck_mask = 4'd0;
    logic [3:0] stuck_val = 4'd0;
    logic [3:0] corrupt [256];

    // Observed outputs gathered per instance
    logic [3:0] a_v    [NI];
    logic [3:0] b_v    [NI];
    logic       busy_v [NI];
    logic       done_v [NI];
    logic       pass_v [NI];
    logic [8:0] err_v  [NI];
    logic       fv_v   [NI];
    logic [3:0] ffa_v  [NI];
    logic [3:0] ffb_v  [NI];
    logic [3:0] ffy_v  [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        quad_gate_tester_if bus_if ();
        logic [7:0] ab_d;
        logic [7:0] ab_src;

        quad_gate_tester #(
            .OP            (op_of(gi)),
            .SETTLE_CYCLES (s_of(gi))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_if)
        );

        always @(posedge clk) ab_d <= {bus_if.a, bus_if.b};

        assign ab_src       = model_delay ? ab_d : {bus_if.a, bus_if.b};
        assign bus_if.start = start_drv;
        assign bus_if.y     = ((gate_fn(model_op, ab_src[7:4], ab_src[3:0]) ^ corrupt[ab_src])
                               & ~stuck_mask) | (stuck_val & stuck_mask);

        assign a_v[gi]    = bus_if.a;
        assign b_v[gi]    = bus_if.b;
        assign busy_v[gi] = bus_if.busy;
        assign done_v[gi] = bus_if.done;
        assign pass_v[gi] = bus_if.pass;
        assign err_v[gi]  = bus_if.err_count;
        assign fv_v[gi]   = bus_if.fail_valid;
        assign ffa_v[gi]  = bus_if.first_fail_a;
        assign ffb_v[gi]  = bus_if.first_fail_b;
        assign ffy_v[gi]  = bus_if.first_fail_y;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference results
    int         exp_err [NI];
    logic       exp_fv  [NI];
    logic [3:0] exp_ffa [NI];
    logic [3:0] exp_ffb [NI];
    logic [3:0] exp_ffy [NI];

    function automatic logic [3:0] model_y(input logic [7:0] ab);
        return ((gate_fn(model_op, ab[7:4], ab[3:0]) ^ corrupt[ab]) & ~stuck_mask)
               | (stuck_val & stuck_mask);
    endfunction

    // Walks the 256 vectors in order. The y seen at the compare of vector k
    // is the model output for vector k, except when the model has a register
    // delay and the vector is held a single cycle: then y still reflects the
    // previous vector (the idle 0/0 inputs for k=0, since each sweep follows
    // a reset).
    task automatic compute_ref();
        for (int i = 0; i < NI; i++) begin
            exp_err[i] = 0;
            exp_fv[i]  = 1'b0;
            exp_ffa[i] = 4'd0;
            exp_ffb[i] = 4'd0;
            exp_ffy[i] = 4'd0;
            for (int k = 0; k < 256; k++) begin
                logic [7:0] cur;
                logic [7:0] src;
                logic [3:0] obs;
                logic [3:0] expv;
                cur  = 8'(k);
                src  = (model_delay && s_of(i) == 1) ? ((k == 0) ? 8'd0 : 8'(k - 1)) : cur;
                obs  = model_y(src);
                expv = gate_fn(2'(op_of(i)), cur[7:4], cur[3:0]);
                if (obs != expv) begin
                    exp_err[i]++;
                    if (!exp_fv[i]) begin
                        exp_fv[i]  = 1'b1;
                        exp_ffa[i] = cur[7:4];
                        exp_ffb[i] = cur[3:0];
                        exp_ffy[i] = obs;
                    end
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        start_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_model(input logic [1:0] op, input logic dly,
                             input logic [3:0] smask, input logic [3:0] sval);
        model_op    = op;
        model_delay = dly;
        stuck_mask  = smask;
        stuck_val   = sval;
        for (int k = 0; k < 256; k++) corrupt[k] = 4'd0;
    endtask

    // One start pulse; the edge after the pulse is E0 and sample n is taken
    // 1 time unit after edge E0+n.
    task automatic pulse_start();
        @(posedge clk);
        #1 start_drv = 1'b1;
        @(posedge clk);
        #1 start_drv = 1'b0;
    endtask

    task automatic do_sweep(input string name, input bit with_reset);
        int done_at  [NI];
        int done_cnt [NI];
        int busy_cnt [NI];
        if (with_reset) apply_reset();
        compute_ref();
        for (int i = 0; i < NI; i++) begin
            done_at[i]  = -1;
            done_cnt[i] = 0;
            busy_cnt[i] = 0;
        end
        pulse_start();
        for (int n = 0; n <= WINDOW; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < NI; i++) begin
                if (busy_v[i]) busy_cnt[i]++;
                if (done_v[i]) begin
                    done_cnt[i]++;
                    if (done_at[i] < 0) begin
                        done_at[i] = n;
                        check_val($sformatf("%s i%0d busy_at_done", name, i),
                                  32'(busy_v[i]), 32'd0);
                    end
                end
                if (n == 60) begin
                    check_val($sformatf("%s i%0d vec_at_60", name, i),
                              32'({a_v[i], b_v[i]}), 32'(60 / s_of(i)));
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("%s i%0d done_at", name, i), 32'(done_at[i]), 32'(256 * s_of(i)));
            check_val($sformatf("%s i%0d done_pulses", name, i), 32'(done_cnt[i]), 32'd1);
            check_val($sformatf("%s i%0d busy_cycles", name, i), 32'(busy_cnt[i]),
                      32'(256 * s_of(i)));
            check_val($sformatf("%s i%0d err_count", name, i), 32'(err_v[i]), 32'(exp_err[i]));
            check_val($sformatf("%s i%0d pass", name, i), 32'(pass_v[i]),
                      32'(exp_err[i] == 0));
            check_val($sformatf("%s i%0d fail_valid", name, i), 32'(fv_v[i]), 32'(exp_fv[i]));
            check_val($sformatf("%s i%0d ff_a", name, i), 32'(ffa_v[i]), 32'(exp_ffa[i]));
            check_val($sformatf("%s i%0d ff_b", name, i), 32'(ffb_v[i]), 32'(exp_ffb[i]));
            check_val($sformatf("%s i%0d ff_y", name, i), 32'(ffy_v[i]), 32'(exp_ffy[i]));
            check_val($sformatf("%s i%0d ab_hold", name, i), 32'({a_v[i], b_v[i]}), 32'hFF);
            $display("sweep %s inst%0d op=%0d settle=%0d: err_count=%0d pass=%0b done_at=%0d",
                     name, i, op_of(i), s_of(i), err_v[i], pass_v[i], done_at[i]);
        end
    endtask

    task automatic abort_run();
        int done_cnt;
        apply_reset();
        set_model(2'd0, 1'b0, 4'd0, 4'd0);
        done_cnt = 0;
        pulse_start();
        for (int n = 0; n <= 100; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < NI; i++) begin
                if (done_v[i]) done_cnt++;
                if (n == 60) begin
                    check_val($sformatf("abort i%0d restart_ignored", i),
                              32'({a_v[i], b_v[i]}), 32'(60 / s_of(i)));
                end
                if (n == 100) begin
                    check_val($sformatf("abort i%0d busy", i), 32'(busy_v[i]), 32'd0);
                    check_val($sformatf("abort i%0d err_count", i), 32'(err_v[i]), 32'd0);
                    check_val($sformatf("abort i%0d fail_valid", i), 32'(fv_v[i]), 32'd0);
                    check_val($sformatf("abort i%0d ab", i), 32'({a_v[i], b_v[i]}), 32'd0);
                end
            end
            if (n == 50) start_drv = 1'b1;
            if (n == 51) start_drv = 1'b0;
            if (n == 99) rst = 1'b1;
        end
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) if (done_v[i] || busy_v[i]) done_cnt++;
        end
        check_val("abort no_done_no_busy", 32'(done_cnt), 32'd0);
        $display("abort: rst mid-sweep, idle activity count=%0d", done_cnt);
        do_sweep("after_abort", 1'b0);
    endtask

    initial begin
        int idle_bad;
        for (int k = 0; k < 256; k++) corrupt[k] = 4'd0;

        // Reset values and idle behaviour
        apply_reset();
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("rst i%0d outs", i),
                      32'({busy_v[i], done_v[i], pass_v[i], fv_v[i], a_v[i], b_v[i]}), 32'd0);
            check_val($sformatf("rst i%0d err_count", i), 32'(err_v[i]), 32'd0);
            check_val($sformatf("rst i%0d ff", i), 32'({ffa_v[i], ffb_v[i], ffy_v[i]}), 32'd0);
        end
        idle_bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++)
                if (busy_v[i] || done_v[i] || a_v[i] != 4'd0 || b_v[i] != 4'd0 || err_v[i] != 9'd0)
                    idle_bad++;
        end
        check_val("idle no_activity", 32'(idle_bad), 32'd0);
        $display("reset: idle 20 cycles, activity count=%0d", idle_bad);

        // Directed gate models
        set_model(2'd0, 1'b0, 4'd0, 4'd0);
        do_sweep("ideal_or", 1'b1);
        set_model(2'd0, 1'b0, 4'b0001, 4'b0000);
        do_sweep("or_y0_stuck0", 1'b1);
        set_model(2'd0, 1'b1, 4'd0, 4'd0);
        do_sweep("or_delayed", 1'b1);
        set_model(2'd3, 1'b0, 4'd0, 4'd0);
        do_sweep("ideal_nand", 1'b1);

        // Abort and re-run
        abort_run();

        // Randomized gate models
        for (int r = 0; r < 6; r++) begin
            set_model(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                      4'($urandom_range(0, 15)));
            for (int k = 0; k < 256; k++)
                corrupt[k] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            do_sweep($sformatf("rand%0d", r), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
